// File: rtl/fc_pkg.sv
// fc_pkg: FSM state type, accumulator sizing and output saturation helpers for fc_layer_par.
package fc_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } fc_state_e;

    localparam int unsigned SAT_W = 128;

    // N full-scale T x T products cannot overflow this width.
    function automatic int unsigned acc_width(input int unsigned t, input int unsigned n);
        return 2 * t + $clog2(n);
    endfunction

    // Clamp to the signed t-bit range, optionally zeroing negatives (ReLU).
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             t,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (SAT_W'(1) <<< (t - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        if (relu && (r < SAT_W'(0))) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one MAC lane; accumulates a row dot product, then shifts, saturates and applies ReLU.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter  int unsigned T    = 16,
    parameter  int unsigned N    = 8,
    parameter  int unsigned FRAC = 0,
    parameter  int unsigned R    = 1,
    localparam int unsigned AW   = acc_width(T, N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_en_i,
    input  logic                 first_i,
    input  logic                 res_en_i,
    input  logic signed [AW-1:0] init_i,
    input  logic signed [T-1:0]  w_i,
    input  logic signed [T-1:0]  x_i,
    output logic signed [T-1:0]  res_o
);

    logic signed [2*T-1:0] prod;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  shifted;
    logic signed [T-1:0]   res_q;
    logic signed [T-1:0]   res_d;

    // The result is taken from the final sum in the same cycle it is accumulated.
    always_comb begin
        prod  = (2*T)'(w_i) * (2*T)'(x_i);
        acc_d = acc_q;
        if (acc_en_i) begin
            acc_d = (first_i ? init_i : acc_q) + AW'(prod);
        end
        shifted = acc_d >>> FRAC;
        res_d   = res_q;
        if (res_en_i) begin
            res_d = T'(sat_relu(SAT_W'(shifted), T, R != 0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/fc_layer_par.sv
// fc_layer_par: y = act((W*x) >> FRAC) with P parallel lanes and a run-time loaded weight RAM.
// Define FC_BIAS_EN to add a bias RAM and its write port; lanes then start from bias << FRAC.
module fc_layer_par
    import fc_pkg::*;
#(
    parameter int unsigned M    = 16,
    parameter int unsigned N    = 8,
    parameter int unsigned T    = 16,
    parameter int unsigned P    = 4,
    parameter int unsigned R    = 1,
    parameter int unsigned FRAC = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           input_valid,
    output logic                           input_ready,
    input  logic signed [T-1:0]            input_data,
    output logic                           output_valid,
    input  logic                           output_ready,
    output logic signed [T-1:0]            output_data,
    input  logic                           w_wr_en,
    input  logic [$clog2(M*N)-1:0]         w_addr,
    input  logic signed [T-1:0]            w_data,
`ifdef FC_BIAS_EN
    input  logic                           b_wr_en,
    input  logic [(M > 1 ? $clog2(M) : 1)-1:0] b_addr,
    input  logic signed [T-1:0]            b_data,
`endif
    output logic                           w_ready
);

    localparam int unsigned G   = M / P;
    localparam int unsigned WAW = $clog2(M*N);
    localparam int unsigned XW  = $clog2(N);
    localparam int unsigned KW  = $clog2(N + 2);
    localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned OW  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned AW  = acc_width(T, N);

    fc_state_e           state_q, state_d;
    logic [XW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [GW-1:0]       g_q, g_d;
    logic [OW-1:0]       o_q, o_d;
    logic                in_rdy_q, in_rdy_d;
    logic                w_rdy_q, w_rdy_d;
    logic                out_vld_q, out_vld_d;
    logic signed [T-1:0] out_data_q, out_data_d;

    logic signed [T-1:0] w_mem [M*N];
    logic signed [T-1:0] x_q [N];
    logic signed [T-1:0] x_rd_q;
    logic signed [T-1:0] lane_res [P];
    logic signed [AW-1:0] lane_init [P];

    logic mac_acc_en;
    logic mac_first;
    logic mac_res_en;
    logic mac_rd_en;

    // k=0 issues column 0 reads, k=1..N accumulate, k=N+1 loads the output register.
    assign mac_rd_en  = (state_q == S_MAC) && (k_q < KW'(N));
    assign mac_acc_en = (state_q == S_MAC) && (k_q != '0) && (k_q <= KW'(N));
    assign mac_first  = (k_q == KW'(1));
    assign mac_res_en = (state_q == S_MAC) && (k_q == KW'(N));

    always_ff @(posedge clk) begin
        if (w_wr_en && w_rdy_q) begin
            w_mem[w_addr] <= w_data;
        end
        if (input_valid && in_rdy_q) begin
            x_q[cnt_q] <= input_data;
        end
        if (mac_rd_en) begin
            x_rd_q <= x_q[XW'(k_q)];
        end
    end

`ifdef FC_BIAS_EN
    localparam int unsigned BAW = (M > 1) ? $clog2(M) : 1;
    logic signed [T-1:0] b_mem [M];

    always_ff @(posedge clk) begin
        if (b_wr_en && w_rdy_q) begin
            b_mem[b_addr] <= b_data;
        end
    end
`endif

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [WAW-1:0]      rd_addr;
        logic signed [T-1:0] w_rd_q;

        assign rd_addr = WAW'((32'(g_q) * P + 32'(p)) * N) + WAW'(k_q);

        always_ff @(posedge clk) begin
            if (mac_rd_en) begin
                w_rd_q <= w_mem[rd_addr];
            end
        end

`ifdef FC_BIAS_EN
        logic signed [T-1:0] b_rd_q;

        always_ff @(posedge clk) begin
            b_rd_q <= b_mem[BAW'(32'(g_q) * P + 32'(p))];
        end

        assign lane_init[p] = AW'(b_rd_q) <<< FRAC;
`else
        assign lane_init[p] = '0;
`endif

        fc_mac_lane #(
            .T    (T),
            .N    (N),
            .FRAC (FRAC),
            .R    (R)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .acc_en_i (mac_acc_en),
            .first_i  (mac_first),
            .res_en_i (mac_res_en),
            .init_i   (lane_init[p]),
            .w_i      (w_rd_q),
            .x_i      (x_rd_q),
            .res_o    (lane_res[p])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        g_d        = g_q;
        o_d        = o_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        case (state_q)
            S_LOAD: begin
                if (input_valid && in_rdy_q) begin
                    if (cnt_q == XW'(N - 1)) begin
                        cnt_d   = '0;
                        k_d     = '0;
                        g_d     = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + XW'(1);
                    end
                end
            end
            S_MAC: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(N + 1)) begin
                    k_d        = '0;
                    o_d        = '0;
                    out_vld_d  = 1'b1;
                    out_data_d = lane_res[0];
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_vld_q && output_ready) begin
                    if (o_q == OW'(P - 1)) begin
                        out_vld_d = 1'b0;
                        if (g_q == GW'(G - 1)) begin
                            cnt_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            g_d     = g_q + GW'(1);
                            k_d     = '0;
                            state_d = S_MAC;
                        end
                    end else begin
                        o_d        = o_q + OW'(1);
                        out_data_d = lane_res[o_q + OW'(1)];
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        in_rdy_d = (state_d == S_LOAD);
        w_rdy_d  = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            k_q        <= '0;
            g_q        <= '0;
            o_q        <= '0;
            in_rdy_q   <= 1'b0;
            w_rdy_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            g_q        <= g_d;
            o_q        <= o_d;
            in_rdy_q   <= in_rdy_d;
            w_rdy_q    <= w_rdy_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign input_ready  = in_rdy_q;
    assign w_ready      = w_rdy_q;
    assign output_valid = out_vld_q;
    assign output_data  = out_data_q;

endmodule

// File: tb/tb_fc_layer_par.sv
// tb_fc_layer_par: directed bench for fc_layer_par (linear, ReLU and 8-bit saturation instances).
// Build with FC_BIAS_EN defined to exercise the bias port as well.
module tb_fc_layer_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic rst;

    logic                in_valid;
    logic signed [15:0]  in_data;
    logic                out_ready;
    logic                w_wr_en;
    logic [2:0]          w_addr;
    logic signed [15:0]  w_data;
    logic                a_in_rdy, a_out_vld, a_w_rdy;
    logic signed [15:0]  a_out_data;
    logic                r_in_rdy, r_out_vld, r_w_rdy;
    logic signed [15:0]  r_out_data;

    logic                s_in_valid;
    logic signed [7:0]   s_in_data;
    logic                s_out_ready;
    logic                s_w_wr_en;
    logic [1:0]          s_w_addr;
    logic signed [7:0]   s_w_data;
    logic                s_in_rdy, s_out_vld, s_w_rdy;
    logic signed [7:0]   s_out_data;

`ifdef FC_BIAS_EN
    logic                b_wr_en;
    logic [1:0]          b_addr;
    logic signed [15:0]  b_data;
    logic                s_b_wr_en;
    logic [0:0]          s_b_addr;
    logic signed [7:0]   s_b_data;
`endif

    int wa[8];
    int exp_a[4];
    int exp_r[4];

    fc_layer_par #(.M(4), .N(2), .T(16), .P(2), .R(0), .FRAC(0)) dut_a (
        .clk (clk), .reset (rst),
        .input_valid (in_valid), .input_ready (a_in_rdy), .input_data (in_data),
        .output_valid (a_out_vld), .output_ready (out_ready), .output_data (a_out_data),
        .w_wr_en (w_wr_en), .w_addr (w_addr), .w_data (w_data),
`ifdef FC_BIAS_EN
        .b_wr_en (b_wr_en), .b_addr (b_addr), .b_data (b_data),
`endif
        .w_ready (a_w_rdy)
    );

    fc_layer_par #(.M(4), .N(2), .T(16), .P(2), .R(1), .FRAC(0)) dut_r (
        .clk (clk), .reset (rst),
        .input_valid (in_valid), .input_ready (r_in_rdy), .input_data (in_data),
        .output_valid (r_out_vld), .output_ready (out_ready), .output_data (r_out_data),
        .w_wr_en (w_wr_en), .w_addr (w_addr), .w_data (w_data),
`ifdef FC_BIAS_EN
        .b_wr_en (b_wr_en), .b_addr (b_addr), .b_data (b_data),
`endif
        .w_ready (r_w_rdy)
    );

    fc_layer_par #(.M(2), .N(2), .T(8), .P(2), .R(0), .FRAC(0)) dut_s (
        .clk (clk), .reset (rst),
        .input_valid (s_in_valid), .input_ready (s_in_rdy), .input_data (s_in_data),
        .output_valid (s_out_vld), .output_ready (s_out_ready), .output_data (s_out_data),
        .w_wr_en (s_w_wr_en), .w_addr (s_w_addr), .w_data (s_w_data),
`ifdef FC_BIAS_EN
        .b_wr_en (s_b_wr_en), .b_addr (s_b_addr), .b_data (s_b_data),
`endif
        .w_ready (s_w_rdy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_w(input int a, input int d);
        w_wr_en = 1'b1;
        w_addr  = 3'(a);
        w_data  = 16'(d);
        step();
        w_wr_en = 1'b0;
    endtask

    task automatic wr_s(input int a, input int d);
        s_w_wr_en = 1'b1;
        s_w_addr  = 2'(a);
        s_w_data  = 8'(d);
        step();
        s_w_wr_en = 1'b0;
    endtask

`ifdef FC_BIAS_EN
    task automatic wr_b(input int a, input int d);
        b_wr_en = 1'b1;
        b_addr  = 2'(a);
        b_data  = 16'(d);
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic wr_sb(input int a, input int d);
        s_b_wr_en = 1'b1;
        s_b_addr  = 1'(a);
        s_b_data  = 8'(d);
        step();
        s_b_wr_en = 1'b0;
    endtask
`endif

    task automatic send_x(input int x0, input int x1);
        int t;
        t = 0;
        while (a_in_rdy !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        check("in_ready_wait", a_in_rdy, 1);
        in_valid = 1'b1;
        in_data  = 16'(x0);
        step();
        in_data  = 16'(x1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_s(input int x0, input int x1);
        int t;
        t = 0;
        while (s_in_rdy !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        check("s_in_ready_wait", s_in_rdy, 1);
        s_in_valid = 1'b1;
        s_in_data  = 8'(x0);
        step();
        s_in_data  = 8'(x1);
        step();
        s_in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_at);
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            out_ready = 1'b1;
            while (a_out_vld !== 1'b1 && t < 40) begin
                step();
                t++;
            end
            check("out_valid", a_out_vld, 1);
            if (i == 2) check("group_latency", t, 4);
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    check("stall_hold", a_out_data, exp_a[i]);
                    check("stall_in_ready", a_in_rdy, 0);
                    w_wr_en = (c == 0);
                    w_addr  = 3'd4;
                    w_data  = 16'sd77;
                    step();
                    w_wr_en = 1'b0;
                end
                out_ready = 1'b1;
            end
            check("out_a", a_out_data, exp_a[i]);
            check("r_valid", r_out_vld, 1);
            check("out_r", r_out_data, exp_r[i]);
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic collect_s(input int e);
        for (int i = 0; i < 2; i++) begin
            int t;
            t = 0;
            s_out_ready = 1'b1;
            while (s_out_vld !== 1'b1 && t < 40) begin
                step();
                t++;
            end
            check("sat_valid", s_out_vld, 1);
            check("sat_data", s_out_data, e);
            step();
        end
        s_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_wr_en = 1'b0; w_addr = '0; w_data = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        s_w_wr_en = 1'b0; s_w_addr = '0; s_w_data = '0;
`ifdef FC_BIAS_EN
        b_wr_en = 1'b0; b_addr = '0; b_data = '0;
        s_b_wr_en = 1'b0; s_b_addr = '0; s_b_data = '0;
`endif

        // Reset held for 3 cycles under random stimulus
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom);
            w_wr_en   = 1'($urandom);
            w_addr    = 3'($urandom);
            w_data    = 16'($urandom);
            step();
            check("rst_out_valid", a_out_vld, 0);
            check("rst_in_ready", a_in_rdy, 0);
            check("rst_out_data", a_out_data, 0);
            check("rst_w_ready", a_w_rdy, 0);
        end
        in_valid = 1'b0; out_ready = 1'b0; w_wr_en = 1'b0;
        rst = 1'b0;
        check("rel_in_ready_before_edge", a_in_rdy, 0);
        step();
        check("rel_in_ready", a_in_rdy, 1);
        check("rel_w_ready", a_w_rdy, 1);
        check("rel_r_w_ready", r_w_rdy, 1);
        check("rel_s_in_ready", s_in_rdy, 1);

        wa = '{1, 2, 3, 4, -1, 0, 0, -5};
        for (int i = 0; i < 8; i++) wr_w(i, wa[i]);
        for (int i = 0; i < 4; i++) wr_s(i, 127);
`ifdef FC_BIAS_EN
        for (int i = 0; i < 4; i++) wr_b(i, 0);
        for (int i = 0; i < 2; i++) wr_sb(i, 0);
`endif

        // Basic dataflow with first-output latency of N+2
        send_x(10, 20);
        check("in_ready_drop", a_in_rdy, 0);
        check("r_in_ready_drop", r_in_rdy, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("first_latency", a_out_vld, (i == 4) ? 1 : 0);
        end
        exp_a = '{50, 110, -10, -100};
        exp_r = '{50, 110, 0, 0};
        collect(-1);

        // Backpressure on the second output plus an ignored weight write
        send_x(10, 20);
        collect(1);

        // Saturation at T=8
        send_s(127, 127);
        collect_s(127);
        send_s(-128, -128);
        collect_s(-128);

        // Reset asserted while outputs are pending
        send_x(10, 20);
        begin
            int t;
            t = 0;
            while (a_out_vld !== 1'b1 && t < 40) begin
                step();
                t++;
            end
        end
        check("pre_rst_valid", a_out_vld, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", a_out_vld, 0);
        check("rst_async_data", a_out_data, 0);
        step();
        rst = 1'b0;
        step();
        check("rst_out_in_ready", a_in_rdy, 1);

`ifdef FC_BIAS_EN
        for (int i = 0; i < 4; i++) wr_b(i, 1);
`endif

        // Reset in the middle of the MAC phase; weights must survive
        send_x(1, 1);
        step();
        step();
        check("mid_mac_valid", a_out_vld, 0);
        rst = 1'b1;
        #1;
        check("mid_mac_rst_valid", a_out_vld, 0);
        check("mid_mac_rst_in_ready", a_in_rdy, 0);
        step();
        rst = 1'b0;
        step();
        send_x(1, 1);
`ifdef FC_BIAS_EN
        exp_a = '{4, 8, 0, -4};
        exp_r = '{4, 8, 0, 0};
`else
        exp_a = '{3, 7, -1, -5};
        exp_r = '{3, 7, 0, 0};
`endif
        collect(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_layer_par.md
Name: fc_layer_par

Overview:
Parametrised fully-connected layer computing y = act((W·x) >> FRAC), where W is M×N, x has length N and y has length M. Weights live in an internal RAM loaded at run time through a write port, so no weights are hardcoded. P MAC lanes compute P rows per pass. The input vector streams in and the results stream out over valid/ready handshakes, and the block chains directly with other layer blocks.

Parameters:
M, 16, output vector length (rows); must be a multiple of P
N, 8, input vector length (columns); N ≥ 2
T, 16, signed data width of inputs, weights and outputs
P, 4, parallel MAC lanes; 1 ≤ P ≤ M
R, 1, 1 = ReLU on outputs, 0 = linear
FRAC, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
input_valid  in  1  input_data is valid
input_ready  out  1  block accepts an x element
input_data  in  T  signed x element, index order 0..N-1
output_valid  out  1  output_data is valid
output_ready  in  1  downstream accepts
output_data  out  T  signed y element, index order 0..M-1
w_wr_en  in  1  weight write strobe
w_addr  in  clog2(M*N)  weight address; W[i][j] is at i*N+j
w_data  in  T  signed weight
w_ready  out  1  weight writes are honoured

Behaviour:
- Reset: clk and reset are the only reset-sensitive timing; the reset is asynchronous and active-high.
  - Reset values: input_ready=0, output_valid=0, output_data=0, w_ready=0. All counters and accumulators clear.
  - The weight RAM and the x buffer are not reset.
  - input_ready and w_ready go to 1 on the first clock edge after reset deasserts.
- FSM states: S_LOAD, S_MAC, S_OUT.
  - S_LOAD:
    - input_ready=1 and w_ready=1.
    - Each input handshake writes x[cnt]; cnt increments.
    - Weight writes take effect on the cycle of the strobe. w_wr_en is ignored outside S_LOAD.
    - After the handshake with cnt=N-1, go to S_MAC with group g=0, and drop input_ready and w_ready the next cycle.
  - S_MAC:
    - Lane p accumulates W[g*P+p][j]·x[j] for j=0..N-1.
    - The RAM read is synchronous (1-cycle latency), so the phase lasts N+1 cycles.
    - Accumulators load 0 on the first product.
  - Post-process:
    - acc >>> FRAC (arithmetic shift).
    - Saturate to the signed T range [-2^(T-1), 2^(T-1)-1].
    - If R=1, negative results become 0.
    - Results are registered per lane; then go to S_OUT.
  - S_OUT:
    - Present lanes 0..P-1 in order.
    - output_data is held stable while output_valid=1 and output_ready=0.
    - After the handshake of lane P-1: if g < M/P-1, set g++ and return to S_MAC; otherwise return to S_LOAD with cnt=0.
- Latency:
  - First output_valid is asserted exactly N+2 cycles after the last input handshake.
  - Likewise, the first output of group g+1 is asserted N+2 cycles after the final handshake of group g.
- Throughput: one output per cycle when output_ready stays high.
- Widths:
  - Accumulator is 2T+clog2(N) bits, so it has no internal overflow.
  - Saturation applies only at the output.
- Boundary cases:
  - input_valid while input_ready=0 is ignored.
  - output_ready without output_valid has no effect.
  - Reset mid-operation discards the partial vector and any pending outputs.
  - P=M gives a single group. P=1 gives a serial implementation.

Optional Feature:
- FC_BIAS_EN defined:
  - Adds ports b_wr_en (1), b_addr (clog2(M)) and b_data (T), subject to the same S_LOAD gating as weight writes.
  - Adds a bias RAM of M entries.
  - Lane accumulators are initialised with sign-extended bias[row] << FRAC instead of 0.
  - Latency is unchanged.
- FC_BIAS_EN undefined: the bias ports and bias RAM are absent, and accumulators start at 0.

Decomposition:
- Package fc_pkg holds:
  - the state enum (S_LOAD, S_MAC, S_OUT);
  - the accumulator width localparam function;
  - a saturate/ReLU function parametrised by T.
- One sub-module, fc_mac_lane (multiply, accumulate, shift, saturate, ReLU), is instantiated P times via generate.
- The top level holds the FSM, the x buffer, the weight RAM with P read ports, and the output mux.

Test Plan:
- Reset check: hold reset for 3 cycles with random stimulus → output_valid=0, input_ready=0, output_data=0. Release → input_ready=1 one edge later.
- Basic dataflow, config M=4, N=2, P=2, T=16, R=0, FRAC=0, W={[1,2],[3,4],[-1,0],[0,-5]}, x=[10,20]:
  - outputs are 50, 110, -10, -100 in order;
  - the first output_valid appears 4 cycles after the last input handshake.
- ReLU: same stimulus with R=1 → outputs 50, 110, 0, 0.
- Saturation, T=8, N=2, all W=127:
  - x=[127,127] → every output is 127;
  - x=[-128,-128] with R=0 → every output is -128.
- Backpressure: hold output_ready low for 5 cycles on the second output → output_data holds 110, and input_ready stays 0 throughout. A w_wr_en strobe during S_OUT does not change later results.
- Reset mid-S_MAC, then a new x=[1,1] with the same W:
  - output_valid drops immediately;
  - outputs are 3, 7, -1, -5, showing the weights were retained;
  - with FC_BIAS_EN and bias=[1,1,1,1], outputs are 4, 8, 0, -4.
